// File: rtl/script_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : script_sequencer_pkg
//  Description : Shared definitions for the kitchen script engine sequencer.
//                Holds the opcode and function-field encodings, the i_sign
//                selector values and their feedback_sig bit positions, and
//                the FSM state encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package script_sequencer_pkg;

    // Opcodes, instruction bits [2:0]
    localparam logic [2:0] c_OP_NOP    = 3'b000;
    localparam logic [2:0] c_OP_ACTION = 3'b001;
    localparam logic [2:0] c_OP_JUMP   = 3'b010;
    localparam logic [2:0] c_OP_WAIT   = 3'b011;
    localparam logic [2:0] c_OP_HALT   = 3'b111;

    // JUMP function field, instruction bits [4:3]
    localparam logic [1:0] c_JMP_IF     = 2'b00;
    localparam logic [1:0] c_JMP_IFN    = 2'b01;
    localparam logic [1:0] c_JMP_ALWAYS = 2'b10;
    localparam logic [1:0] c_JMP_NEVER  = 2'b11;

    // WAIT function field, instruction bits [4:3]
    localparam logic [1:0] c_WT_SIG   = 2'b00;
    localparam logic [1:0] c_WT_NSIG  = 2'b01;
    localparam logic [1:0] c_WT_DELAY = 2'b10;
    localparam logic [1:0] c_WT_NOP   = 2'b11;

    // i_sign selector values, instruction bits [7:5]
    localparam logic [2:0] c_SIGN_PLAYER_READY   = 3'd0;
    localparam logic [2:0] c_SIGN_PLAYER_HASITEM = 3'd1;
    localparam logic [2:0] c_SIGN_TARGET_READY   = 3'd2;
    localparam logic [2:0] c_SIGN_TARGET_HASITEM = 3'd3;

    // Bit positions on the feedback_sig status bus
    localparam int c_FB_PLAYER_READY   = 2;
    localparam int c_FB_PLAYER_HASITEM = 3;
    localparam int c_FB_TARGET_READY   = 4;
    localparam int c_FB_TARGET_HASITEM = 5;

    // FSM state encodings
    localparam int         c_ST_W    = 3;
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_F0   = 3'd1;
    localparam logic [2:0] c_ST_F1   = 3'd2;
    localparam logic [2:0] c_ST_F2   = 3'd3;
    localparam logic [2:0] c_ST_EXEC = 3'd4;
    localparam logic [2:0] c_ST_ACT  = 3'd5;
    localparam logic [2:0] c_ST_WAIT = 3'd6;
    localparam logic [2:0] c_ST_HALT = 3'd7;

endpackage
`default_nettype wire

// File: rtl/script_sequencer_feedback_mux.sv
`default_nettype none
// ============================================================================
//  Module      : script_sequencer_feedback_mux
//  Description : Selects one kitchen status bit from feedback_sig according to
//                the instruction i_sign field. Selectors 4..7 name no signal
//                and read as 0. Shared by the branch and wait paths.
//  Ports       : i_sign     - instruction signal selector (3 bits)
//                i_feedback - kitchen status bus (8 bits)
//                o_sig      - selected status bit
//  Revision    : 1.0 - initial release
// ============================================================================
module script_sequencer_feedback_mux
    import script_sequencer_pkg::*;
(
    input  logic [2:0] i_sign,
    input  logic [7:0] i_feedback,
    output logic       o_sig
);

    always_comb begin
        o_sig = 1'b0;
        case (i_sign)
            c_SIGN_PLAYER_READY:   o_sig = i_feedback[c_FB_PLAYER_READY];
            c_SIGN_PLAYER_HASITEM: o_sig = i_feedback[c_FB_PLAYER_HASITEM];
            c_SIGN_TARGET_READY:   o_sig = i_feedback[c_FB_TARGET_READY];
            c_SIGN_TARGET_HASITEM: o_sig = i_feedback[c_FB_TARGET_HASITEM];
            default:               o_sig = 1'b0;
        endcase
    end

    // Status bits the script cannot address
    logic w_unused_fb;
    assign w_unused_fb = ^{i_feedback[7:6], i_feedback[1:0]};

endmodule
`default_nettype wire

// File: rtl/script_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : script_sequencer
//  Description : Fetch/decode/execute controller for the kitchen script
//                engine. Fetches 2-byte instructions from byte-wide script
//                memory, runs NOP/ACTION/JUMP/WAIT/HALT, owns the PC, issues
//                player actions over valid/ready and evaluates kitchen
//                feedback for branches and waits.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                start                - run pulse, honoured in IDLE/HALT only
//                mem_addr / mem_rdata - script memory, 1-cycle read latency
//                feedback_sig         - kitchen status bus
//                act_valid/func/num   - action request, act_ready accepts
//                pc, busy, halted     - sequencer status
//                err, timeout         - sticky illegal-op / wait-timeout flags
//  Revision    : 1.0 - initial release
// ============================================================================
module script_sequencer
    import script_sequencer_pkg::*;
#(
    parameter logic [7:0] START_PC     = 8'h00,
    parameter int         WAIT_TIMEOUT = 1000,
    parameter int         TMO_W        = 16
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic [7:0] feedback_sig,
    output logic       act_valid,
    output logic [1:0] act_func,
    output logic [7:0] act_num,
    input  logic       act_ready,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted,
    output logic       err,
    output logic       timeout
);

    localparam logic [TMO_W-1:0] c_TMO_LIMIT = TMO_W'(WAIT_TIMEOUT);

    logic [c_ST_W-1:0] r_state, w_state_nxt;
    logic [7:0]        r_pc, w_pc_nxt;
    logic [7:0]        r_lo, r_hi;
    logic [TMO_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic              r_timeout, w_timeout_nxt;

    logic [2:0]        w_op;
    logic [1:0]        w_func;
    logic              w_sig;
    logic [7:0]        w_pc_inc;
    logic [7:0]        w_pc_jmp;
    logic [TMO_W-1:0]  w_cnt_inc;
    logic              w_jump_taken;
    logic              w_wait_met;
    logic              w_tmo_hit;

    assign w_op      = r_lo[2:0];
    assign w_func    = r_lo[4:3];
    assign w_pc_inc  = r_pc + 8'd2;
    // Offset is i_num words; the 9-bit sum is truncated so large offsets wrap backwards
    assign w_pc_jmp  = r_pc + {r_hi[6:0], 1'b0};
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_tmo_hit = (WAIT_TIMEOUT != 0) && (w_cnt_inc == c_TMO_LIMIT);

    script_sequencer_feedback_mux u_feedback_mux (
        .i_sign     (r_lo[7:5]),
        .i_feedback (feedback_sig),
        .o_sig      (w_sig)
    );

    always_comb begin
        w_jump_taken = 1'b0;
        case (w_func)
            c_JMP_IF:     w_jump_taken = w_sig;
            c_JMP_IFN:    w_jump_taken = ~w_sig;
            c_JMP_ALWAYS: w_jump_taken = 1'b1;
            c_JMP_NEVER:  w_jump_taken = 1'b0;
            default:      w_jump_taken = 1'b0;
        endcase
    end

    // Evaluated in EXEC (counter not yet running) and in every WAIT cycle.
    // A fixed delay of N spends N cycles in WAIT; N=0 finishes straight from EXEC.
    always_comb begin
        w_wait_met = 1'b0;
        case (w_func)
            c_WT_SIG:   w_wait_met = w_sig;
            c_WT_NSIG:  w_wait_met = ~w_sig;
            c_WT_DELAY: w_wait_met = (r_state == c_ST_EXEC) ? (r_hi == 8'd0)
                                                            : (w_cnt_inc == TMO_W'(r_hi));
            c_WT_NOP:   w_wait_met = 1'b1;
            default:    w_wait_met = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_timeout_nxt = r_timeout;
        case (r_state)
            c_ST_IDLE, c_ST_HALT: begin
                if (start) begin
                    w_pc_nxt      = START_PC;
                    w_err_nxt     = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = c_ST_F0;
                end
            end
            c_ST_F0: w_state_nxt = c_ST_F1;
            c_ST_F1: w_state_nxt = c_ST_F2;
            c_ST_F2: w_state_nxt = c_ST_EXEC;
            c_ST_EXEC: begin
                w_cnt_nxt = '0;
                case (w_op)
                    c_OP_NOP: begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = c_ST_F0;
                    end
                    c_OP_ACTION: w_state_nxt = c_ST_ACT;
                    c_OP_JUMP: begin
                        w_pc_nxt    = w_jump_taken ? w_pc_jmp : w_pc_inc;
                        w_state_nxt = c_ST_F0;
                    end
                    c_OP_WAIT: begin
                        if (w_wait_met) begin
                            w_pc_nxt    = w_pc_inc;
                            w_state_nxt = c_ST_F0;
                        end else begin
                            w_state_nxt = c_ST_WAIT;
                        end
                    end
                    c_OP_HALT: w_state_nxt = c_ST_HALT;
                    default: begin
                        // Illegal opcode: stop with pc left on the offending instruction
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_ST_HALT;
                    end
                endcase
            end
            c_ST_ACT: begin
                if (act_ready) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = c_ST_F0;
                end
            end
            c_ST_WAIT: begin
                if (w_wait_met) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = c_ST_F0;
                end else if (w_tmo_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_pc_nxt      = w_pc_inc;
                    w_state_nxt   = c_ST_F0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pc      <= START_PC;
            r_lo      <= 8'h00;
            r_hi      <= 8'h00;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_timeout <= w_timeout_nxt;
            if (r_state == c_ST_F1) r_lo <= mem_rdata;
            if (r_state == c_ST_F2) r_hi <= mem_rdata;
        end
    end

    // Address is presented in F0 (low byte) and F1 (high byte); data returns a cycle later
    always_comb begin
        mem_addr = 8'h00;
        if (r_state == c_ST_F0) mem_addr = r_pc;
        if (r_state == c_ST_F1) mem_addr = r_pc + 8'd1;
    end

    assign act_valid = (r_state == c_ST_ACT);
    assign act_func  = act_valid ? w_func : 2'b00;
    assign act_num   = act_valid ? r_hi   : 8'h00;
    assign pc        = r_pc;
    assign busy      = (r_state != c_ST_IDLE) && (r_state != c_ST_HALT);
    assign halted    = (r_state == c_ST_HALT);
    assign err       = r_err;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_script_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_script_sequencer
//  Description : Self-checking bench for script_sequencer. A behavioural
//                script memory feeds the DUT; expected pc transitions and
//                action requests are queued as each program is set up and
//                consumed by monitors as the DUT produces them.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_script_sequencer;

    localparam int c_WT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] feedback_sig;
    logic       act_valid;
    logic [1:0] act_func;
    logic [7:0] act_num;
    logic       act_ready;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       err;
    logic       timeout;

    always #5 clk = ~clk;

    script_sequencer #(
        .START_PC     (8'h00),
        .WAIT_TIMEOUT (c_WT),
        .TMO_W        (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .feedback_sig (feedback_sig),
        .act_valid    (act_valid),
        .act_func     (act_func),
        .act_num      (act_num),
        .act_ready    (act_ready),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .err          (err),
        .timeout      (timeout)
    );

    // Script memory with one cycle of read latency
    logic [7:0] mem [256];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q_pc [$];
    logic [9:0] q_act [$];
    logic [7:0] last_exp_pc;
    logic [7:0] prev_pc;
    bit         mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue an expected pc value only when it differs from the last expected one
    function automatic void push_pc(input logic [7:0] v);
        if (v != last_exp_pc) q_pc.push_back(v);
        last_exp_pc = v;
    endfunction

    function automatic logic [7:0] ins(input int sign, input int func, input int op);
        return 8'((sign << 5) | (func << 3) | op);
    endfunction

    task automatic put(input int addr, input logic [7:0] lo, input logic [7:0] hi);
        mem[addr]     = lo;
        mem[addr + 1] = hi;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h07;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halted(input int budget);
        for (int i = 0; i < budget && !halted; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("halt_wait", halted, 1'b1);
    endtask

    // Start, then count clock edges after the start edge until pc reaches target
    task automatic run_count(input logic [7:0] target, input int raise_at, output int n);
        n = -1;
        pulse_start();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (pc == target) begin
                n = k;
                break;
            end
            if (k == raise_at) feedback_sig[4] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && pc !== prev_pc) begin
            if (q_pc.size() == 0) check_eq("pc_unexpected", pc, prev_pc);
            else check_eq("pc_seq", pc, q_pc.pop_front());
            prev_pc = pc;
        end
    end

    always @(posedge clk) begin
        if (mon_en && act_valid && act_ready) begin
            if (q_act.size() == 0) check_eq("act_unexpected", act_valid, 1'b0);
            else check_eq("act_req", {act_func, act_num}, q_act.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [1:0] jf [4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic       jfb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] jexp [4] = '{8'd10, 8'd6, 8'd6, 8'd10};

        rst = 1'b1; start = 1'b0; act_ready = 1'b0; feedback_sig = 8'h00;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flags", {busy, halted, err, timeout, act_valid}, 5'b0);
        check_eq("rst_pc", pc, 8'h00);
        check_eq("rst_mem_addr", mem_addr, 8'h00);
        check_eq("rst_act", {act_func, act_num}, 10'h0);
        @(negedge clk);
        rst = 1'b0;
        prev_pc = pc;
        last_exp_pc = 8'h00;
        mon_en = 1'b1;

        // NOP, NOP, HALT
        clear_mem();
        put(0, ins(0, 0, 0), 8'h00);
        put(2, ins(0, 0, 0), 8'h00);
        put(4, ins(0, 0, 7), 8'h00);
        push_pc(8'd0); push_pc(8'd2); push_pc(8'd4);
        pulse_start();
        check_eq("t1_busy", busy, 1'b1);
        repeat (11) @(posedge clk);
        #1 check_eq("t1_halt_early", halted, 1'b0);
        @(posedge clk);
        #1;
        check_eq("t1_halt_c13", {halted, busy}, 2'b10);
        check_eq("t1_pc", pc, 8'd4);

        // ACTION with a slow executor
        clear_mem();
        put(0, ins(0, 1, 1), 8'h05);
        put(2, ins(0, 0, 7), 8'h00);
        push_pc(8'd0); push_pc(8'd2);
        q_act.push_back({2'b01, 8'h05});
        pulse_start();
        act_ready = 1'b1;
        @(posedge clk);
        #1 act_ready = 1'b0;
        for (int i = 0; i < 20 && !act_valid; i++) @(negedge clk);
        check_eq("act_wait", act_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("act_hold", {act_valid, act_func, act_num}, {1'b1, 2'b01, 8'h05});
            if (i == 3) act_ready = 1'b1;
            @(negedge clk);
        end
        act_ready = 1'b0;
        check_eq("act_drop", act_valid, 1'b0);
        check_eq("act_pc", pc, 8'd2);
        wait_halted(50);

        // Conditional jumps on player_hasitem
        clear_mem();
        put(0, ins(0, 0, 0), 8'h00);
        put(2, ins(0, 0, 0), 8'h00);
        put(6, ins(0, 0, 7), 8'h00);
        put(10, ins(0, 0, 7), 8'h00);
        for (int c = 0; c < 4; c++) begin
            put(4, ins(1, int'(jf[c]), 2), 8'd3);
            feedback_sig = {4'h0, jfb[c], 3'b000};
            push_pc(8'd0); push_pc(8'd2); push_pc(8'd4); push_pc(jexp[c]);
            pulse_start();
            wait_halted(60);
            check_eq("jmp_cond_pc", pc, jexp[c]);
        end

        // Unconditional, backward-wrapping and unaddressable-signal jumps
        clear_mem();
        feedback_sig = 8'hFF;
        put(0, ins(5, 0, 2), 8'd8);
        put(2, ins(0, 2, 2), 8'd2);
        put(6, ins(0, 2, 2), 8'hFF);
        put(4, ins(5, 1, 2), 8'd5);
        put(14, ins(0, 0, 7), 8'h00);
        put(16, ins(0, 0, 7), 8'h00);
        push_pc(8'd0); push_pc(8'd2); push_pc(8'd6); push_pc(8'd4); push_pc(8'd14);
        pulse_start();
        wait_halted(80);
        check_eq("jmp_wrap_pc", pc, 8'd14);

        // WAIT for target_ready, then timeout, then fixed delays
        clear_mem();
        feedback_sig = 8'h00;
        put(0, ins(2, 0, 3), 8'h00);
        put(2, ins(0, 0, 7), 8'h00);
        push_pc(8'd0); push_pc(8'd2);
        run_count(8'd2, 5, n);
        check_eq("wait_sig_cycles", n, 6);
        wait_halted(20);
        check_eq("wait_sig_tmo", timeout, 1'b0);
        feedback_sig = 8'h00;

        push_pc(8'd0); push_pc(8'd2);
        run_count(8'd2, -1, n);
        check_eq("wait_tmo_cycles", n, 4 + c_WT);
        wait_halted(20);
        check_eq("wait_tmo_flag", timeout, 1'b1);

        put(0, ins(0, 2, 3), 8'd4);
        push_pc(8'd0); push_pc(8'd2);
        run_count(8'd2, -1, n);
        check_eq("wait_dly4_cycles", n, 8);
        check_eq("wait_tmo_cleared", timeout, 1'b0);
        wait_halted(20);

        put(0, ins(0, 2, 3), 8'd0);
        push_pc(8'd0); push_pc(8'd2);
        run_count(8'd2, -1, n);
        check_eq("wait_dly0_cycles", n, 4);
        wait_halted(20);

        put(0, ins(2, 1, 3), 8'd0);
        push_pc(8'd0); push_pc(8'd2);
        run_count(8'd2, -1, n);
        check_eq("wait_nsig_cycles", n, 4);
        wait_halted(20);

        // Illegal opcode, then restart clears err
        clear_mem();
        put(0, ins(0, 0, 0), 8'h00);
        put(2, ins(0, 0, 5), 8'h00);
        push_pc(8'd0); push_pc(8'd2);
        pulse_start();
        wait_halted(40);
        check_eq("illegal_flags", {err, halted}, 2'b11);
        check_eq("illegal_pc", pc, 8'd2);
        put(2, ins(0, 0, 7), 8'h00);
        push_pc(8'd0); push_pc(8'd2);
        pulse_start();
        check_eq("err_cleared", err, 1'b0);
        wait_halted(40);
        check_eq("restart_pc", pc, 8'd2);

        // Reset in the middle of an outstanding action
        clear_mem();
        put(0, ins(0, 0, 0), 8'h00);
        put(2, ins(0, 2, 1), 8'h33);
        push_pc(8'd0); push_pc(8'd2);
        pulse_start();
        for (int i = 0; i < 30 && !act_valid; i++) @(negedge clk);
        check_eq("rst_act_wait", act_valid, 1'b1);
        check_eq("rst_act_req", {act_func, act_num}, {2'b10, 8'h33});
        push_pc(8'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_act", {act_valid, busy}, 2'b00);
        check_eq("rst_mid_pc", pc, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_idle", {act_valid, busy, halted}, 3'b000);

        repeat (2) @(negedge clk);
        check_eq("pc_queue_empty", q_pc.size(), 0);
        check_eq("act_queue_empty", q_act.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
